slew_brownout_monitor: RTL and testbench



---
 rtl/slew_brownout_monitor_pkg.sv | 13 +
 rtl/slew_brownout_monitor_channel.sv | 108 ++++++++++
 rtl/slew_brownout_monitor.sv | 66 ++++++
 tb/tb_slew_brownout_monitor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/slew_brownout_monitor_pkg.sv
// bod_pkg: shared state encoding, width helper and default parameters for the brownout monitor
package bod_pkg;
  typedef enum logic [1:0] {ARMED, PENDING, TRIPPED} bod_state_t;
  localparam int BOD_NUM_CH  = 2;
  localparam int BOD_ADC_W   = 20;
  localparam int BOD_LIMIT_W = 12;
  localparam int BOD_DEPTH   = 4;
  localparam int BOD_CONFIRM = 2;
  localparam int BOD_HOLD    = 8;
  function automatic int bod_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/slew_brownout_monitor_channel.sv
// slew_brownout_channel: one rail's sample history, fall computation and ARMED/PENDING/TRIPPED FSM
//   i_accept    sample for this channel accepted this cycle (already qualified by bod_warn)
//   i_warn      soft-BOD enable; low invalidates history and re-arms
//   i_crit      hard BOD; forces TRIPPED while high
//   i_data      sample value, i_limit max allowed fall over DEPTH samples
//   o_drop      fall of i_data versus the oldest stored sample
//   o_trip_next next-state TRIPPED decode, o_brownout registered TRIPPED flag
module slew_brownout_channel import bod_pkg::*; #(
  parameter int ADC_W   = BOD_ADC_W,
  parameter int LIMIT_W = BOD_LIMIT_W,
  parameter int DEPTH   = BOD_DEPTH,
  parameter int CONFIRM = BOD_CONFIRM,
  parameter int HOLD    = BOD_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_accept,
  input  logic               i_warn,
  input  logic               i_crit,
  input  logic [ADC_W-1:0]   i_data,
  input  logic [LIMIT_W-1:0] i_limit,
  output logic [ADC_W-1:0]   o_drop,
  output logic               o_trip_next,
  output logic               o_brownout
);
  localparam int PW = bod_clog2(DEPTH);
  localparam int FW = bod_clog2(DEPTH + 1);
  localparam int VW = bod_clog2(CONFIRM + 1);
  localparam int HW = bod_clog2(HOLD + 1);
  logic [ADC_W-1:0] r_hist [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [FW-1:0]    r_fill;
  bod_state_t       r_state, w_state;
  logic [VW-1:0]    r_vcnt, w_vcnt;
  logic [HW-1:0]    r_hcnt, w_hcnt;
  logic [ADC_W-1:0] w_old;
  logic             w_full, w_viol;
  // r_ptr always addresses the oldest entry, which is also the slot the new sample overwrites
  assign w_old       = r_hist[r_ptr];
  assign o_drop      = (w_old > i_data) ? w_old - i_data : '0;
  assign w_full      = r_fill == FW'(DEPTH);
  assign w_viol      = w_full && (o_drop > ADC_W'(i_limit));
  assign o_trip_next = w_state == TRIPPED;
  always_comb begin
    w_state = r_state;
    w_vcnt  = r_vcnt;
    w_hcnt  = r_hcnt;
    if (i_crit) begin
      w_state = TRIPPED;
      w_vcnt  = '0;
      w_hcnt  = '0;
    end else if (!i_warn) begin
      w_state = ARMED;
      w_vcnt  = '0;
      w_hcnt  = '0;
    end else if (i_accept) begin
      case (r_state)
        ARMED: if (w_viol) begin
          w_state = (CONFIRM == 1) ? TRIPPED : PENDING;
          w_vcnt  = (CONFIRM == 1) ? '0 : VW'(1);
          w_hcnt  = '0;
        end
        PENDING: if (w_viol) begin
          w_vcnt = r_vcnt + 1'b1;
          if (w_vcnt == VW'(CONFIRM)) begin
            w_state = TRIPPED;
            w_vcnt  = '0;
            w_hcnt  = '0;
          end
        end else begin
          w_state = ARMED;
          w_vcnt  = '0;
        end
        TRIPPED: if (w_viol) w_hcnt = '0;
        else begin
          w_hcnt = r_hcnt + 1'b1;
          if (w_hcnt == HW'(HOLD)) begin
            w_state = ARMED;
            w_hcnt  = '0;
          end
        end
        default: w_state = ARMED;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
      r_ptr      <= '0;
      r_fill     <= '0;
      r_state    <= ARMED;
      r_vcnt     <= '0;
      r_hcnt     <= '0;
      o_brownout <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_vcnt     <= w_vcnt;
      r_hcnt     <= w_hcnt;
      o_brownout <= o_trip_next;
      if (!i_warn) r_fill <= '0;
      else if (i_accept) begin
        r_hist[r_ptr] <= i_data;
        r_ptr         <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        if (!w_full) r_fill <= r_fill + 1'b1;
      end
    end
  end
endmodule

// File: rtl/slew_brownout_monitor.sv
// slew_brownout_monitor: multi-channel rate-of-fall brownout detector on a time-multiplexed ADC stream
//   i_adc_valid/i_adc_ch/i_adc_data  sample stream, out-of-range channels ignored
//   i_rate_limit                     max allowed fall over DEPTH samples
//   i_bod_warn/i_bod_crit            per-channel slope enable and hard-BOD override
//   o_brownout/o_brownout_any        registered per-channel flags and their OR
//   o_drop/o_drop_ch                 last computed fall and its channel (debug)
module slew_brownout_monitor import bod_pkg::*; #(
  parameter int NUM_CH  = BOD_NUM_CH,
  parameter int ADC_W   = BOD_ADC_W,
  parameter int LIMIT_W = BOD_LIMIT_W,
  parameter int DEPTH   = BOD_DEPTH,
  parameter int CONFIRM = BOD_CONFIRM,
  parameter int HOLD    = BOD_HOLD,
  localparam int CH_W   = bod_clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_adc_valid,
  input  logic [CH_W-1:0]    i_adc_ch,
  input  logic [ADC_W-1:0]   i_adc_data,
  input  logic [LIMIT_W-1:0] i_rate_limit,
  input  logic [NUM_CH-1:0]  i_bod_warn,
  input  logic [NUM_CH-1:0]  i_bod_crit,
  output logic [NUM_CH-1:0]  o_brownout,
  output logic               o_brownout_any,
  output logic [ADC_W-1:0]   o_drop,
  output logic [CH_W-1:0]    o_drop_ch
);
  logic [NUM_CH-1:0] w_accept, w_trip_next;
  logic [ADC_W-1:0]  w_drop [NUM_CH];
  logic [ADC_W-1:0]  w_sel_drop;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_accept[c] = i_adc_valid && (i_adc_ch == CH_W'(c)) && i_bod_warn[c];
    slew_brownout_channel #(
      .ADC_W(ADC_W), .LIMIT_W(LIMIT_W), .DEPTH(DEPTH), .CONFIRM(CONFIRM), .HOLD(HOLD)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .i_accept(w_accept[c]),
      .i_warn(i_bod_warn[c]),
      .i_crit(i_bod_crit[c]),
      .i_data(i_adc_data),
      .i_limit(i_rate_limit),
      .o_drop(w_drop[c]),
      .o_trip_next(w_trip_next[c]),
      .o_brownout(o_brownout[c])
    );
  end
  always_comb begin
    w_sel_drop = '0;
    for (int k = 0; k < NUM_CH; k++) if (w_accept[k]) w_sel_drop = w_drop[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_brownout_any <= 1'b0;
      o_drop         <= '0;
      o_drop_ch      <= '0;
    end else begin
      o_brownout_any <= |w_trip_next;
      if (|w_accept) begin
        o_drop    <= w_sel_drop;
        o_drop_ch <= i_adc_ch;
      end
    end
  end
endmodule

// File: tb/tb_slew_brownout_monitor.sv
// tb_slew_brownout_monitor: directed self-checking bench for slew_brownout_monitor
module tb_slew_brownout_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        adc_valid;
  logic [1:0]  adc_ch;
  logic [19:0] adc_data;
  logic [11:0] rate_limit;
  logic [2:0]  bod_warn, bod_crit;
  logic [2:0]  brownout;
  logic        brownout_any;
  logic [19:0] drop;
  logic [1:0]  drop_ch;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  slew_brownout_monitor #(
    .NUM_CH(3), .ADC_W(20), .LIMIT_W(12), .DEPTH(4), .CONFIRM(2), .HOLD(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_adc_valid(adc_valid),
    .i_adc_ch(adc_ch),
    .i_adc_data(adc_data),
    .i_rate_limit(rate_limit),
    .i_bod_warn(bod_warn),
    .i_bod_crit(bod_crit),
    .o_brownout(brownout),
    .o_brownout_any(brownout_any),
    .o_drop(drop),
    .o_drop_ch(drop_ch)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] ch, input int d);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = 20'(d);
    @(posedge clk);
    #1;
    adc_valid = 1'b0;
  endtask
  int fast [3]   = '{950, 880, 800};
  int fast_d [3] = '{50, 120, 200};
  int rec_d [5]  = '{200, 150, 80, 0, 0};
  int ch1v [7]   = '{2000, 2000, 2000, 2000, 1800, 1600, 1400};
  int ch1b [7]   = '{0, 0, 0, 0, 0, 2, 2};
  int wfall [6]  = '{1000, 900, 800, 700, 600, 500};
  initial begin
    rst_n = 1'b0;
    adc_valid = 1'b0;
    adc_ch = '0;
    adc_data = '0;
    rate_limit = 12'd100;
    bod_warn = 3'b001;
    bod_crit = 3'b000;
    #12;
    chk("rst_bo", int'(brownout), 0);
    chk("rst_any", int'(brownout_any), 0);
    chk("rst_drop", int'(drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(2'd0, 1000 - 10 * i);
      chk("slow_bo", int'(brownout), 0);
    end
    chk("slow_drop", int'(drop), 40);
    for (int i = 0; i < 4; i++) send(2'd0, 1000);
    for (int i = 0; i < 3; i++) begin
      send(2'd0, fast[i]);
      chk("fast_drop", int'(drop), fast_d[i]);
      chk("fast_bo", int'(brownout), (i == 2) ? 1 : 0);
    end
    chk("fast_any", int'(brownout_any), 1);
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 800);
      chk("rel_drop", int'(drop), rec_d[i]);
      chk("rel_bo", int'(brownout), (i == 4) ? 0 : 1);
    end
    chk("rel_any", int'(brownout_any), 0);
    @(negedge clk);
    bod_crit = 3'b010;
    @(posedge clk);
    #1;
    chk("crit_bo", int'(brownout), 2);
    chk("crit_any", int'(brownout_any), 1);
    @(posedge clk);
    #1;
    chk("crit_hold", int'(brownout), 2);
    @(negedge clk);
    bod_crit = 3'b000;
    @(posedge clk);
    #1;
    chk("crit_off_bo", int'(brownout), 0);
    chk("crit_off_any", int'(brownout_any), 0);
    @(negedge clk);
    bod_warn = 3'b011;
    for (int i = 0; i < 7; i++) begin
      send(2'd0, 1000);
      chk("il_ch0_drop", int'(drop), 0);
      send(2'd1, ch1v[i]);
      chk("il_ch1_bo", int'(brownout), ch1b[i]);
      chk("il_ch1_dch", int'(drop_ch), 1);
      send(2'd3, 0);
      chk("il_g_dch", int'(drop_ch), 1);
      chk("il_g_bo", int'(brownout), ch1b[i]);
    end
    chk("il_drop", int'(drop), 600);
    @(negedge clk);
    bod_warn = 3'b001;
    @(posedge clk);
    #1;
    chk("warn_off_bo1", int'(brownout), 0);
    send(2'd0, 850);
    chk("wd_pend_drop", int'(drop), 150);
    chk("wd_pend_bo", int'(brownout), 0);
    @(negedge clk);
    bod_warn = 3'b000;
    @(negedge clk);
    bod_warn = 3'b001;
    for (int i = 0; i < 6; i++) begin
      send(2'd0, wfall[i]);
      chk("wd_bo", int'(brownout), (i == 5) ? 1 : 0);
    end
    chk("wd_drop", int'(drop), 400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bo", int'(brownout), 0);
    chk("arst_any", int'(brownout_any), 0);
    chk("arst_drop", int'(drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd0, 1000);
    chk("post_drop0", int'(drop), 0);
    send(2'd0, 500);
    send(2'd0, 200);
    send(2'd0, 100);
    chk("post_bo4", int'(brownout), 0);
    send(2'd0, 0);
    chk("post_drop5", int'(drop), 1000);
    chk("post_bo5", int'(brownout), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
